// File: rtl/bch_pkg.sv
// bch_pkg: BCH(63,51) t=2 code constants, FSM states and GF(2^6) helpers
package bch_pkg;
  localparam int N = 63;
  localparam int K = 51;
  localparam int M = 6;
  localparam logic [M:0] PRIM_POLY = 7'b1000011;
  localparam logic [12:0] GEN_POLY = 13'h1539;
  localparam int NPAR = $clog2(GEN_POLY) - 1;
  typedef enum logic [1:0] {RECV, SOLVE, CHIEN, OUT} state_t;
  typedef logic [M-1:0] gf_t;
  function automatic gf_t gf_mul_alpha(gf_t a);
    return {a[M-2:0], 1'b0} ^ (a[M-1] ? PRIM_POLY[M-1:0] : '0);
  endfunction
  function automatic gf_t gf_mul_alpha2(gf_t a);
    return gf_mul_alpha(gf_mul_alpha(a));
  endfunction
  function automatic gf_t gf_mul_alpha3(gf_t a);
    return gf_mul_alpha(gf_mul_alpha2(a));
  endfunction
  // Shift-and-reduce, MSB of b first (Horner over the bits of b)
  function automatic gf_t gf_mul(gf_t a, gf_t b);
    gf_t r;
    r = '0;
    for (int i = M - 1; i >= 0; i--) r = gf_mul_alpha(r) ^ (b[i] ? a : '0);
    return r;
  endfunction
endpackage

// File: rtl/gf64_mul.sv
// gf64_mul: combinational general multiplier in GF(2^6) modulo x^6+x+1
module gf64_mul
  import bch_pkg::*;
(
  input  logic [5:0] a,
  input  logic [5:0] b,
  output logic [5:0] p
);
  assign p = gf_mul(a, b);
endmodule

// File: rtl/bch_decoder.sv
// bch_decoder: serial BCH(63,51) t=2 decoder with syndrome, locator and Chien search
module bch_decoder
  import bch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  output logic        ready_out,
  input  logic        data_in,
  output logic        valid_out,
  input  logic        ready_in,
  output logic        data_out,
  output logic [50:0] data_out_all,
  output logic [1:0]  err_cnt,
  output logic        uncorrectable
);
  localparam logic [5:0] LAST_IN = 6'(N - 1);
  localparam logic [5:0] LAST_OUT = 6'(K - 1);
  state_t state_q, state_d;
  logic [5:0] cnt_q, cnt_d, pos;
  gf_t s1_q, s1_d, s3_q, s3_d, t1_q, t1_d, t2_q, t2_d, s1_sq, s1_cu;
  logic [1:0] exp_q, exp_d, roots_q, roots_d, err_q, err_d, n_roots;
  logic unc_q, unc_d, root;
  logic [N-1:0] buf_q, buf_d, raw_q, raw_d, fix;
  logic [K-1:0] all_q, all_d;
  gf64_mul u_sq (.a(s1_q), .b(s1_q), .p(s1_sq));
  gf64_mul u_cu (.a(s1_sq), .b(s1_q), .p(s1_cu));
  assign pos = LAST_IN - cnt_q;
  // A zero-syndrome word makes the locator identically zero, so roots only count when errors are expected
  assign root = state_q == CHIEN && exp_q != 2'd0 && !unc_q && (s1_q ^ t1_q ^ t2_q) == '0;
  assign fix = buf_q ^ ({{(N-1){1'b0}}, root} << pos);
  assign n_roots = roots_q + {1'b0, root};
  assign ready_out = state_q == RECV;
  assign valid_out = state_q == OUT;
  assign data_out = valid_out && buf_q[pos];
  assign data_out_all = all_q;
  assign err_cnt = err_q;
  assign uncorrectable = unc_q;
  // Next-state and datapath: receive/syndrome, classify, Chien correct, stream out
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    s1_d = s1_q;
    s3_d = s3_q;
    t1_d = t1_q;
    t2_d = t2_q;
    exp_d = exp_q;
    roots_d = roots_q;
    err_d = err_q;
    unc_d = unc_q;
    buf_d = buf_q;
    raw_d = raw_q;
    all_d = all_q;
    case (state_q)
      RECV: if (valid_in) begin
        buf_d[pos] = data_in;
        raw_d[pos] = data_in;
        s1_d = gf_mul_alpha(s1_q) ^ {{(M-1){1'b0}}, data_in};
        s3_d = gf_mul_alpha3(s3_q) ^ {{(M-1){1'b0}}, data_in};
        cnt_d = cnt_q == LAST_IN ? 6'd0 : cnt_q + 6'd1;
        state_d = cnt_q == LAST_IN ? SOLVE : RECV;
      end
      SOLVE: begin
        exp_d = s1_q == '0 ? 2'd0 : s3_q == s1_cu ? 2'd1 : 2'd2;
        unc_d = s1_q == '0 && s3_q != '0;
        err_d = 2'd0;
        roots_d = 2'd0;
        t1_d = gf_mul_alpha(s1_sq);
        t2_d = gf_mul_alpha2(s3_q ^ s1_cu);
        cnt_d = 6'd0;
        state_d = CHIEN;
      end
      CHIEN: begin
        buf_d = fix;
        roots_d = n_roots;
        t1_d = gf_mul_alpha(t1_q);
        t2_d = gf_mul_alpha2(t2_q);
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == LAST_IN) begin
          unc_d = unc_q || n_roots != exp_q;
          err_d = unc_d ? 2'd0 : n_roots;
          buf_d = unc_d ? raw_q : fix;
          all_d = buf_d[N-1:NPAR];
          s1_d = '0;
          s3_d = '0;
          cnt_d = 6'd0;
          state_d = OUT;
        end
      end
      OUT: if (ready_in) begin
        cnt_d = cnt_q == LAST_OUT ? 6'd0 : cnt_q + 6'd1;
        state_d = cnt_q == LAST_OUT ? RECV : OUT;
      end
      default: state_d = RECV;
    endcase
  end
  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RECV;
      cnt_q <= '0;
      s1_q <= '0;
      s3_q <= '0;
      t1_q <= '0;
      t2_q <= '0;
      exp_q <= '0;
      roots_q <= '0;
      err_q <= '0;
      unc_q <= 1'b0;
      buf_q <= '0;
      raw_q <= '0;
      all_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      s1_q <= s1_d;
      s3_q <= s3_d;
      t1_q <= t1_d;
      t2_q <= t2_d;
      exp_q <= exp_d;
      roots_q <= roots_d;
      err_q <= err_d;
      unc_q <= unc_d;
      buf_q <= buf_d;
      raw_q <= raw_d;
      all_q <= all_d;
    end
  end
endmodule
